// File: rtl/decode_ibuf.sv
// Multi-lane instruction buffer between fetch and decode with register-field pre-decode.
// Circular storage, first-word-fall-through output lanes, flush on redirect.
module decode_ibuf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ENQ_W = 2,
    parameter int unsigned DEQ_W = 2,
    parameter int unsigned XLEN  = 64
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic [ENQ_W-1:0]             in_valid,
    input  logic [ENQ_W*XLEN-1:0]        in_pc,
    input  logic [ENQ_W*32-1:0]          in_instr,
    output logic                         in_ready,
    output logic [DEQ_W-1:0]             out_valid,
    output logic [DEQ_W*XLEN-1:0]        out_pc,
    output logic [DEQ_W*32-1:0]          out_instr,
    output logic [DEQ_W*5-1:0]           out_ra1,
    output logic [DEQ_W*5-1:0]           out_ra2,
    output logic [DEQ_W*5-1:0]           out_rd,
    input  logic [$clog2(DEQ_W+1)-1:0]   out_take,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IW    = 32;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             in_ready_nxt;
    logic [DEQ_W-1:0] out_valid_nxt;
    logic [CNT_W-1:0] nenq;
    logic [CNT_W-1:0] ntake;
    logic             enq_run;
    logic             enq_go;

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [IW-1:0]    mem_instr [DEPTH];

    // Accepted lanes: leading run of set valid bits from lane 0
    always_comb begin
        nenq    = '0;
        enq_run = 1'b1;
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            if (enq_run && in_valid[i]) begin
                nenq = nenq + CNT_W'(1);
            end else begin
                enq_run = 1'b0;
            end
        end
    end

    // Oversized take requests clamp to lane count and occupancy
    always_comb begin
        ntake = CNT_W'(out_take);
        if (ntake > CNT_W'(DEQ_W)) begin
            ntake = CNT_W'(DEQ_W);
        end
        if (ntake > count) begin
            ntake = count;
        end
    end

    assign enq_go = in_ready && !flush;

    // Pointer/occupancy update; flush overrides both enqueue and take
    always_comb begin
        head_nxt      = head + PTR_W'(ntake);
        tail_nxt      = tail;
        count_nxt     = count - ntake;
        out_valid_nxt = '0;
        if (enq_go) begin
            tail_nxt  = tail + PTR_W'(nenq);
            count_nxt = count_nxt + nenq;
        end
        if (flush) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end
        in_ready_nxt = (count_nxt <= CNT_W'(DEPTH - ENQ_W));
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            out_valid_nxt[i] = (CNT_W'(i) < count_nxt);
        end
    end

    // in_ready and out_valid are pure functions of occupancy, so they are
    // registered from the next occupancy and track count exactly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= '0;
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            count     <= count_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Storage is not reset; validity is carried by count alone
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            if (enq_go && (CNT_W'(i) < nenq)) begin
                mem_pc[tail + PTR_W'(i)]    <= in_pc[i*XLEN +: XLEN];
                mem_instr[tail + PTR_W'(i)] <= in_instr[i*IW +: IW];
            end
        end
    end

    for (genvar g = 0; g < DEQ_W; g++) begin : g_lane
        logic [PTR_W-1:0] idx;
        assign idx                       = head + PTR_W'(g);
        assign out_pc[g*XLEN +: XLEN]    = mem_pc[idx];
        assign out_instr[g*IW +: IW]     = mem_instr[idx];
        assign out_ra1[g*5 +: 5]         = mem_instr[idx][19:15];
        assign out_ra2[g*5 +: 5]         = mem_instr[idx][24:20];
        assign out_rd[g*5 +: 5]          = mem_instr[idx][11:7];
    end

endmodule

// File: tb/tb_decode_ibuf.sv
// Self-checking bench for decode_ibuf: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_decode_ibuf;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned ENQ_W = 2;
    localparam int unsigned DEQ_W = 2;
    localparam int unsigned XLEN  = 64;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  flush;
    logic [ENQ_W-1:0]      in_valid;
    logic [ENQ_W*XLEN-1:0] in_pc;
    logic [ENQ_W*32-1:0]   in_instr;
    logic                  in_ready;
    logic [DEQ_W-1:0]      out_valid;
    logic [DEQ_W*XLEN-1:0] out_pc;
    logic [DEQ_W*32-1:0]   out_instr;
    logic [DEQ_W*5-1:0]    out_ra1;
    logic [DEQ_W*5-1:0]    out_ra2;
    logic [DEQ_W*5-1:0]    out_rd;
    logic [1:0]            out_take;
    logic [3:0]            count;

    decode_ibuf #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_ra1(out_ra1), .out_ra2(out_ra2), .out_rd(out_rd),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        fl;
        logic [1:0]  v;
        logic [1:0]  t;
        int unsigned cnt;
        logic        rdy;
        logic [1:0]  val;
    } vec_t;

    ent_t q[$];
    vec_t tbl[17];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare all visible DUT state against the queue model
    task automatic check_model();
        logic [1:0] ev;
        ev = '0;
        for (int i = 0; i < int'(DEQ_W); i++) ev[i] = (i < q.size());
        chk("m_count", 64'(count), 64'(q.size()));
        chk("m_in_ready", 64'(in_ready), 64'(q.size() <= int'(DEPTH - ENQ_W)));
        chk("m_out_valid", 64'(out_valid), 64'(ev));
        for (int i = 0; i < int'(DEQ_W); i++) begin
            if (i < q.size()) begin
                chk("m_pc", out_pc[i*XLEN +: XLEN], q[i].pc);
                chk("m_instr", 64'(out_instr[i*32 +: 32]), 64'(q[i].instr));
                chk("m_ra1", 64'(out_ra1[i*5 +: 5]), 64'(q[i].instr[19:15]));
                chk("m_ra2", 64'(out_ra2[i*5 +: 5]), 64'(q[i].instr[24:20]));
                chk("m_rd", 64'(out_rd[i*5 +: 5]), 64'(q[i].instr[11:7]));
            end
        end
    endtask

    // Model behaviour at a clock edge
    task automatic model_edge(input logic f, input logic [1:0] v, input logic [127:0] pcs,
                              input logic [63:0] ins, input logic [1:0] t);
        bit rdy;
        int nt;
        ent_t e;
        if (f) begin
            q.delete();
        end else begin
            rdy = (q.size() <= int'(DEPTH - ENQ_W));
            nt  = int'(t);
            if (nt > int'(DEQ_W)) nt = int'(DEQ_W);
            if (nt > q.size()) nt = q.size();
            for (int k = 0; k < nt; k++) void'(q.pop_front());
            if (rdy) begin
                for (int k = 0; k < int'(ENQ_W); k++) begin
                    if (!v[k]) break;
                    e.pc    = pcs[k*64 +: 64];
                    e.instr = ins[k*32 +: 32];
                    q.push_back(e);
                end
            end
        end
    endtask

    // One cycle: drive at negedge, check model, clock, then return inputs to idle
    task automatic step(input logic f, input logic [1:0] v, input logic [127:0] pcs,
                        input logic [63:0] ins, input logic [1:0] t);
        @(negedge clk);
        flush = f; in_valid = v; in_pc = pcs; in_instr = ins; out_take = t;
        #1 check_model();
        @(posedge clk);
        model_edge(f, v, pcs, ins, t);
        #1;
        flush = 1'b0; in_valid = '0; out_take = '0;
    endtask

    function automatic logic [63:0] rnd_instr();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pcb;
        logic [63:0] exp_pc;
        logic [63:0] fetch_pc;
        logic        rdy;
        int          ntk;
        logic [1:0]  rv;

        resetn = 1'b0; flush = 1'b0; in_valid = '0; in_pc = '0; in_instr = '0; out_take = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk) resetn = 1'b1;

        // Field extraction
        step(1'b0, 2'b01, {64'h0, 64'h8000_0000}, {32'h0, 32'h00B5_0533}, 2'd0);
        chk("ext_valid", 64'(out_valid), 64'b01);
        chk("ext_rd", 64'(out_rd[4:0]), 64'd10);
        chk("ext_ra1", 64'(out_ra1[4:0]), 64'd10);
        chk("ext_ra2", 64'(out_ra2[4:0]), 64'd11);
        chk("ext_pc", out_pc[63:0], 64'h8000_0000);
        step(1'b0, 2'b00, '0, '0, 2'd1);
        chk("ext_drain", 64'(count), 64'd0);

        // Vector table: {flush, in_valid, take, count after, in_ready after, out_valid after}
        tbl[0]  = '{1'b0, 2'b11, 2'd0, 2, 1'b1, 2'b11};
        tbl[1]  = '{1'b0, 2'b11, 2'd0, 4, 1'b1, 2'b11};
        tbl[2]  = '{1'b0, 2'b11, 2'd0, 6, 1'b1, 2'b11};
        tbl[3]  = '{1'b0, 2'b11, 2'd0, 8, 1'b0, 2'b11};
        tbl[4]  = '{1'b0, 2'b11, 2'd0, 8, 1'b0, 2'b11};
        tbl[5]  = '{1'b0, 2'b00, 2'd3, 6, 1'b1, 2'b11};
        tbl[6]  = '{1'b0, 2'b11, 2'd2, 6, 1'b1, 2'b11};
        tbl[7]  = '{1'b0, 2'b10, 2'd2, 4, 1'b1, 2'b11};
        tbl[8]  = '{1'b0, 2'b01, 2'd2, 3, 1'b1, 2'b11};
        tbl[9]  = '{1'b0, 2'b00, 2'd2, 1, 1'b1, 2'b01};
        tbl[10] = '{1'b0, 2'b00, 2'd2, 0, 1'b1, 2'b00};
        tbl[11] = '{1'b0, 2'b00, 2'd1, 0, 1'b1, 2'b00};
        tbl[12] = '{1'b0, 2'b11, 2'd0, 2, 1'b1, 2'b11};
        tbl[13] = '{1'b0, 2'b11, 2'd0, 4, 1'b1, 2'b11};
        tbl[14] = '{1'b0, 2'b01, 2'd0, 5, 1'b1, 2'b11};
        tbl[15] = '{1'b1, 2'b11, 2'd2, 0, 1'b1, 2'b00};
        tbl[16] = '{1'b0, 2'b01, 2'd0, 1, 1'b1, 2'b01};
        pcb = 64'h1000;
        for (int r = 0; r < 17; r++) begin
            step(tbl[r].fl, tbl[r].v, {pcb + 64'd4, pcb}, rnd_instr(), tbl[r].t);
            chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].cnt));
            chk($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].rdy));
            chk($sformatf("tbl%0d_valid", r), 64'(out_valid), 64'(tbl[r].val));
            pcb = pcb + 64'd8;
        end
        chk("flush_lane0_pc", out_pc[63:0], pcb - 64'd8);

        // Wrap-around ordering: fetch holds a group while in_ready is low
        step(1'b1, 2'b00, '0, '0, 2'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11, {64'(k*8 + 4), 64'(k*8)}, rnd_instr(), 2'd0);
        exp_pc   = 64'h0;
        fetch_pc = 64'h20;
        for (int k = 0; k < 12; k++) begin
            ntk = (q.size() < 2) ? q.size() : 2;
            for (int j = 0; j < ntk; j++) begin
                chk("wrap_pc", out_pc[j*XLEN +: XLEN], exp_pc);
                exp_pc = exp_pc + 64'd4;
            end
            rdy = (q.size() <= int'(DEPTH - ENQ_W));
            step(1'b0, 2'b11, {fetch_pc + 64'd4, fetch_pc}, rnd_instr(), 2'd2);
            if (rdy) fetch_pc = fetch_pc + 64'd8;
            chk("wrap_count", 64'(count == 4'd6 || count == 4'd8), 64'd1);
        end

        // Asynchronous reset between edges
        step(1'b1, 2'b00, '0, '0, 2'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b11, {$urandom, $urandom, $urandom, $urandom}, rnd_instr(), 2'd0);
        chk("pre_arst_count", 64'(count), 64'd6);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_valid", 64'(out_valid), 64'd0);
        q.delete();
        @(negedge clk);
        #1 resetn = 1'b1;
        step(1'b0, 2'b01, {64'h0, 64'h100}, rnd_instr(), 2'd0);
        chk("post_arst_pc", out_pc[63:0], 64'h100);
        chk("post_arst_valid", 64'(out_valid), 64'b01);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rv = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom);
            step(($urandom_range(0, 19) == 0), rv, {$urandom, $urandom, $urandom, $urandom},
                 rnd_instr(), 2'($urandom_range(0, 3)));
        end
        @(negedge clk);
        #1 check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ibuf.md
Name: decode_ibuf

Overview:
- Parametrised instruction buffer plus register-field pre-decode between fetch and decode.
- Generalises the single-instruction fetch-to-decode hand-off to ENQ_W lanes in and DEQ_W lanes out, with DEPTH-entry circular storage.
- Supports flush on redirect.
- Each output lane presents pc, raw instruction and extracted ra1/ra2/rd so the downstream decoder and register-file read ports can start directly.

Parameters:
- DEPTH, 8: number of entries; power of two; must be >= max(ENQ_W, DEQ_W).
- ENQ_W, 2: fetch lanes accepted per cycle.
- DEQ_W, 2: decode lanes presented per cycle.
- XLEN, 64: pc width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all contents (branch/jump redirect).
- in_valid  in  ENQ_W  lane-valid mask; lane 0 is the oldest.
- in_pc  in  ENQ_W*XLEN  per-lane pc; lane i occupies bits [i*XLEN +: XLEN].
- in_instr  in  ENQ_W*32  per-lane raw instruction.
- in_ready  out  1  buffer can accept a full ENQ_W group this cycle.
- out_valid  out  DEQ_W  thermometer mask of valid head entries.
- out_pc  out  DEQ_W*XLEN  pc of head+i.
- out_instr  out  DEQ_W*32  raw instruction of head+i.
- out_ra1  out  DEQ_W*5  instr[19:15] of head+i.
- out_ra2  out  DEQ_W*5  instr[24:20] of head+i.
- out_rd  out  DEQ_W*5  instr[11:7] of head+i.
- out_take  in  $clog2(DEQ_W+1)  number of head entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
State and reset
- State: head pointer, tail pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), count register, DEPTH x (XLEN+32) storage.
- Reset (resetn low, asynchronous): head=0, tail=0, count=0. Therefore in_ready=1, out_valid=0, count=0.
- Storage contents are not reset. Outputs of invalid lanes are don't-care, but out_valid must be 0 for them.

Enqueue
- nenq = number of consecutive set bits of in_valid starting at lane 0. Bits above the first zero are ignored.
- in_ready = (count <= DEPTH-ENQ_W), computed from registered count only. It does not credit same-cycle dequeue and has no combinational path from out_take.
- When in_ready=1 and flush=0: lanes 0..nenq-1 are written to tail..tail+nenq-1 (mod DEPTH), and tail += nenq.
- When in_ready=0: the input group is dropped entirely. Fetch is responsible for holding it.

Dequeue
- First-word-fall-through: out lane i shows entry head+i (mod DEPTH).
- out_valid[i] = (i < count).
- An entry enqueued at edge N is visible on the outputs after edge N; enqueue-to-out latency is 1 cycle. There is no bypass.
- ntake = min(out_take, count, DEQ_W); oversized requests are clamped. head += ntake.

Update rules
- Simultaneous enqueue and dequeue: count' = count + nenq - ntake.
- Reads use pre-edge head; writes use pre-edge tail. No hazard, because in_ready guarantees free slots.
- Wrap-around: pointer arithmetic modulo DEPTH. A group straddling index DEPTH-1/0 is written correctly.

Flush
- Takes priority over everything.
- At the edge: head=0, tail=0, count=0. Same-cycle enqueue and take are ignored.
- Outputs are still driven from pre-flush state during the flush cycle; the consumer must ignore them.

Other rules
- Full: count=DEPTH implies in_ready=0 and out_valid all ones (when DEPTH >= DEQ_W).
- Empty: count=0 implies out_valid=0, and out_take is ignored.
- Reset mid-operation: immediate asynchronous clear; the first edge after deassertion behaves as from empty.
- Field extraction is pure slicing and independent of opcode. Consumers qualify the fields with decoded control.

Test Plan:
- Reset and extraction: hold resetn=0 -> count=0, in_ready=1, out_valid=2'b00. Release, enqueue lane0 pc=0x8000_0000 instr=0x00B50533 -> next cycle out_valid=2'b01, out_rd=10, out_ra1=10, out_ra2=11, out_pc=0x8000_0000.
- Fill and full: defaults, in_valid=2'b11 every cycle, out_take=0 -> count 2,4,6,8. in_ready drops to 0 once count=8. A 5th group is dropped and count stays 8.
- Wrap-around ordering: enqueue pcs 0x00..0x1C (8 entries), take 2 per cycle while enqueuing 2 per cycle with pcs 0x20.. -> out_pc stream strictly increasing by 4 across the index 7->0 wrap; count stays 6 or 8 with no loss or duplication.
- Partial and clamped take: count=1 with out_take=2 -> ntake=1, count=0, head advances by 1. Non-contiguous in_valid=2'b10 -> nothing enqueued.
- Flush priority: count=5, in_valid=2'b11, out_take=2, flush=1 -> next cycle count=0, out_valid=0, in_ready=1. The subsequent enqueue appears at lane 0.
- Async reset mid-stream: count=6, drop resetn between edges -> count=0 immediately. After release, an enqueue of pc=0x100 is visible at out lane 0.
